// File: rtl/lgn_pkg.sv
// Shared types and default geometry for the logic-gate network classifier head.
package lgn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        RANK  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_CATEGORIES        = 10;
    localparam int DEF_BITS_PER_CATEGORY = 800;
    localparam int DEF_CHUNK             = 100;

    // Number of cycles the COUNT phase needs to sweep one category.
    function automatic int nchunk(input int bits_per_category, input int chunk);
        return bits_per_category / chunk;
    endfunction

endpackage

// File: rtl/lgn_serial_head_if.sv
// Request/result bundle between the network output and the classifier head.
interface lgn_serial_head_if
    import lgn_pkg::*;
#(
    parameter int CATEGORIES        = DEF_CATEGORIES,
    parameter int BITS_PER_CATEGORY = DEF_BITS_PER_CATEGORY
);
    localparam int SUM_W = $clog2(BITS_PER_CATEGORY + 1);
    localparam int IDX_W = (CATEGORIES > 1) ? $clog2(CATEGORIES) : 1;

    logic                                    start;
    logic [CATEGORIES*BITS_PER_CATEGORY-1:0] in_bits;
    logic                                    busy;
    logic                                    out_valid;
    logic [IDX_W-1:0]                        out_index;
    logic [SUM_W-1:0]                        out_value;
    logic [SUM_W-1:0]                        out_margin;

    modport master (
        output start, in_bits,
        input  busy, out_valid, out_index, out_value, out_margin
    );

    modport slave (
        input  start, in_bits,
        output busy, out_valid, out_index, out_value, out_margin
    );

endinterface

// File: rtl/lgn_serial_head_popcount_chunk.sv
// Combinational population count of one N-bit chunk.
module popcount_chunk #(
    parameter int N = 100
) (
    input  logic [N-1:0]             bits,
    output logic [$clog2(N+1)-1:0]   count
);
    localparam int CW = $clog2(N + 1);

    // NOTE: every variable written in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/lgn_serial_head.sv
// Sequential classifier head: chunked popcount per category, then a serial
// best/runner-up scan producing winner index, score and margin.
module lgn_serial_head
    import lgn_pkg::*;
#(
    parameter int CATEGORIES        = DEF_CATEGORIES,
    parameter int BITS_PER_CATEGORY = DEF_BITS_PER_CATEGORY,
    parameter int CHUNK             = DEF_CHUNK
) (
    input  logic              clk,
    input  logic              reset,
    lgn_serial_head_if.slave  bus
);
    localparam int NCHUNK = nchunk(BITS_PER_CATEGORY, CHUNK);
    localparam int SUM_W  = $clog2(BITS_PER_CATEGORY + 1);
    localparam int IDX_W  = (CATEGORIES > 1) ? $clog2(CATEGORIES) : 1;
    localparam int CNT_W  = $clog2(CHUNK + 1);
    localparam int CK_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (BITS_PER_CATEGORY % CHUNK != 0) begin : g_bad_chunk
        $error("lgn_serial_head: CHUNK must divide BITS_PER_CATEGORY");
    end

    state_t state_q, state_d;
    logic   start_ok;
    logic   last_chunk;
    logic   last_rank;

    logic [CK_W-1:0]  chunk_cnt;
    logic [IDX_W-1:0] rank_idx;
    logic [SUM_W-1:0] acc         [CATEGORIES];
    logic [CHUNK-1:0] chunk_bits  [CATEGORIES];
    logic [CNT_W-1:0] chunk_count [CATEGORIES];

    logic [SUM_W-1:0] acc_sel;
    logic [SUM_W-1:0] best_q, best_d;
    logic [SUM_W-1:0] second_q, second_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    logic             busy_q;
    logic             valid_q;
    logic [IDX_W-1:0] index_q;
    logic [SUM_W-1:0] value_q;
    logic [SUM_W-1:0] margin_q;

    assign last_chunk = (chunk_cnt == CK_W'(NCHUNK - 1));
    assign last_rank  = (rank_idx == IDX_W'(CATEGORIES - 1));

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = COUNT;
                    start_ok = 1'b1;
                end
            end
            COUNT:   if (last_chunk) state_d = RANK;
            RANK:    if (last_rank)  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- chunk select and popcount ----------------
    always_comb begin
        for (int c = 0; c < CATEGORIES; c++) begin
            chunk_bits[c] = '0;
            for (int k = 0; k < NCHUNK; k++) begin
                if (chunk_cnt == CK_W'(k)) begin
                    chunk_bits[c] = bus.in_bits[c*BITS_PER_CATEGORY + k*CHUNK +: CHUNK];
                end
            end
        end
    end

    for (genvar c = 0; c < CATEGORIES; c++) begin : g_pc
        popcount_chunk #(.N(CHUNK)) u_popcount (
            .bits  (chunk_bits[c]),
            .count (chunk_count[c])
        );
    end

    // ---------------- serial ranking step ----------------
    always_comb begin
        acc_sel = '0;
        for (int c = 0; c < CATEGORIES; c++) begin
            if (rank_idx == IDX_W'(c)) acc_sel = acc[c];
        end
    end

    // Strict greater-than keeps the lowest index on ties; an equal score
    // drops into the runner-up slot and yields a zero margin.
    always_comb begin
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        if (rank_idx == '0) begin
            best_d     = acc_sel;
            best_idx_d = '0;
            second_d   = '0;
        end else if (acc_sel > best_q) begin
            second_d   = best_q;
            best_d     = acc_sel;
            best_idx_d = rank_idx;
        end else if (acc_sel > second_q) begin
            second_d   = acc_sel;
        end
    end

    // ---------------- datapath registers ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            chunk_cnt  <= '0;
            rank_idx   <= '0;
            // NOTE: the accumulator array is a handful of registers, not a RAM,
            // so clearing it in reset is cheap and discards partial sums.
            for (int c = 0; c < CATEGORIES; c++) acc[c] <= '0;
            best_q     <= '0;
            second_q   <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            index_q    <= '0;
            value_q    <= '0;
            margin_q   <= '0;
        end else begin
            busy_q <= (state_d == COUNT) || (state_d == RANK);
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        chunk_cnt <= '0;
                        for (int c = 0; c < CATEGORIES; c++) acc[c] <= '0;
                        valid_q   <= 1'b0;
                    end
                end
                COUNT: begin
                    for (int c = 0; c < CATEGORIES; c++) begin
                        acc[c] <= acc[c] + SUM_W'(chunk_count[c]);
                    end
                    chunk_cnt <= chunk_cnt + CK_W'(1);
                    if (last_chunk) rank_idx <= '0;
                end
                RANK: begin
                    best_q     <= best_d;
                    second_q   <= second_d;
                    best_idx_q <= best_idx_d;
                    rank_idx   <= rank_idx + IDX_W'(1);
                    if (last_rank) begin
                        index_q  <= best_idx_d;
                        value_q  <= best_d;
                        margin_q <= best_d - second_d;
                        valid_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_index  = index_q;
    assign bus.out_value  = value_q;
    assign bus.out_margin = margin_q;

endmodule
